axil_regfile_slave: RTL and testbench

- AXI4-Lite responder: the slave end for the team's AXI4-Lite master-side interface tasks (write_data/read_data).
- Holds NUM_REGS read/write registers of DATA_WIDTH bits and exposes them flat to the fabric for control/status wiring.
- Independent write and read FSMs; one outstanding transaction per direction.

---
 rtl/axil_pkg.sv | 27 ++
 rtl/axil_regfile_slave_if.sv | 39 +++
 rtl/axil_reg_bank.sv | 61 ++++++
 rtl/axil_regfile_slave.sv | 187 ++++++++++++++++++
 tb/tb_axil_regfile_slave.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axil_pkg.sv
// Shared types and helpers for the AXI4-Lite register-file slave.
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic {
    WR_IDLE,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_RESP
  } rd_state_t;

  // Word index of a byte address; the caller masks it to the index field width.
  function automatic int unsigned addr_to_index(input logic [63:0] addr,
                                                input int unsigned addr_lsb);
    return 32'(addr >> addr_lsb);
  endfunction

endpackage

// File: rtl/axil_regfile_slave_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface axil_regfile_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axil_reg_bank.sv
// Register storage: byte-strobed write port, combinational read mux and
// a one-cycle write strobe per register.
module axil_reg_bank #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_REGS    = 16,
  parameter int                    IW          = 5,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en,
  input  logic [IW-1:0]                  wr_idx,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic [DATA_WIDTH/8-1:0]        wr_strb,
  input  logic [IW-1:0]                  rd_idx,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int STRB_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // Storage update: only strobed bytes of the addressed register change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VALUE;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_idx == IW'(i)) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (wr_strb[b]) regs[i][8*b +: 8] <= wr_data[8*b +: 8];
          end
        end
      end
    end
  end

  // Write strobe: high for the cycle in which the new value is visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_pulse <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) wr_pulse[i] <= wr_en && (wr_idx == IW'(i));
    end
  end

  // Read mux: an index past the last register reads as zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == IW'(i)) rd_data = regs[i];
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_out[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

endmodule

// File: rtl/axil_regfile_slave.sv
// AXI4-Lite register-file slave with independent write and read FSMs.
// Optional build macro AXIL_REGFILE_SLVERR_EN: out-of-range accesses
// answer SLVERR instead of OKAY.
module axil_regfile_slave
  import axil_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    NUM_REGS    = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  axil_regfile_slave_if.slave            bus,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
  output logic [NUM_REGS-1:0]            reg_wr_pulse
);

  localparam int unsigned ADDR_LSB = $clog2(DATA_WIDTH / 8);
  // One extra index bit for power-of-two counts: the aperture directly
  // above the file decodes out of range instead of aliasing register 0.
  localparam int          IW       = $clog2(NUM_REGS + 1);
  localparam logic [31:0] IDX_MASK = (32'd1 << IW) - 32'd1;

`ifdef AXIL_REGFILE_SLVERR_EN
  localparam resp_t OOR_RESP = SLVERR;
`else
  localparam resp_t OOR_RESP = OKAY;
`endif

  function automatic logic [31:0] full_index(input logic [ADDR_WIDTH-1:0] a);
    return addr_to_index(64'(a), ADDR_LSB) & IDX_MASK;
  endfunction

  function automatic logic [IW-1:0] decode(input logic [ADDR_WIDTH-1:0] a);
    logic [31:0] idx;
    idx = full_index(a);
    return idx[IW-1:0];
  endfunction

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return full_index(a) < 32'(NUM_REGS);
  endfunction

  wr_state_t               wr_state, wr_next;
  rd_state_t               rd_state, rd_next;
  logic                    ready_en;
  logic                    aw_held, w_held;
  logic [ADDR_WIDTH-1:0]   aw_addr_q;
  logic [DATA_WIDTH-1:0]   w_data_q;
  logic [DATA_WIDTH/8-1:0] w_strb_q;
  resp_t                   bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    aw_hs, w_hs, ar_hs, commit;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [DATA_WIDTH/8-1:0] wr_strb;
  logic [DATA_WIDTH-1:0]   bank_rd_data;
  logic                    unused_prot;

  assign unused_prot = ^{bus.awprot, bus.arprot};

  assign bus.awready = ready_en && (wr_state == WR_IDLE) && !aw_held;
  assign bus.wready  = ready_en && (wr_state == WR_IDLE) && !w_held;
  assign bus.arready = ready_en && (rd_state == RD_IDLE);
  assign bus.bvalid  = (wr_state == WR_RESP);
  assign bus.bresp   = bresp_q;
  assign bus.rvalid  = (rd_state == RD_RESP);
  assign bus.rresp   = rresp_q;
  assign bus.rdata   = rdata_q;

  assign aw_hs = bus.awvalid && bus.awready;
  assign w_hs  = bus.wvalid && bus.wready;
  assign ar_hs = bus.arvalid && bus.arready;

  // Commit uses the held copy of a channel if it arrived earlier.
  assign wr_addr = aw_held ? aw_addr_q : bus.awaddr;
  assign wr_data = w_held  ? w_data_q  : bus.wdata;
  assign wr_strb = w_held  ? w_strb_q  : bus.wstrb;

  // Keeps the ready outputs low while reset is asserted.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) ready_en <= 1'b0;
    else          ready_en <= 1'b1;
  end

  // Write FSM state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) wr_state <= WR_IDLE;
    else          wr_state <= wr_next;
  end

  // Write FSM: commit once both address and data are present.
  always_comb begin
    wr_next = wr_state;
    commit  = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        if ((aw_held || aw_hs) && (w_held || w_hs)) begin
          commit  = 1'b1;
          wr_next = WR_RESP;
        end
      end
      WR_RESP: begin
        if (bus.bready) wr_next = WR_IDLE;
      end
      default: wr_next = WR_IDLE;
    endcase
  end

  // Write-side holding registers and response code.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp_q   <= OKAY;
    end else if (commit) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      bresp_q <= in_range(wr_addr) ? OKAY : OOR_RESP;
    end else begin
      if (aw_hs) begin
        aw_held   <= 1'b1;
        aw_addr_q <= bus.awaddr;
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= bus.wdata;
        w_strb_q <= bus.wstrb;
      end
    end
  end

  // Read FSM state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) rd_state <= RD_IDLE;
    else          rd_state <= rd_next;
  end

  // Read FSM: one outstanding read, response held until rready.
  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE: if (ar_hs) rd_next = RD_RESP;
      RD_RESP: if (bus.rready) rd_next = RD_IDLE;
      default: rd_next = RD_IDLE;
    endcase
  end

  // Read data capture: samples the pre-write contents on a same-edge commit.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rdata_q <= '0;
      rresp_q <= OKAY;
    end else if (ar_hs) begin
      if (in_range(bus.araddr)) begin
        rdata_q <= bank_rd_data;
        rresp_q <= OKAY;
      end else begin
        rdata_q <= '0;
        rresp_q <= OOR_RESP;
      end
    end
  end

  axil_reg_bank #(
    .DATA_WIDTH  (DATA_WIDTH),
    .NUM_REGS    (NUM_REGS),
    .IW          (IW),
    .RESET_VALUE (RESET_VALUE)
  ) u_bank (
    .clk      (aclk),
    .rst_n    (aresetn),
    .wr_en    (commit && in_range(wr_addr)),
    .wr_idx   (decode(wr_addr)),
    .wr_data  (wr_data),
    .wr_strb  (wr_strb),
    .rd_idx   (decode(bus.araddr)),
    .rd_data  (bank_rd_data),
    .regs_out (regs_out),
    .wr_pulse (reg_wr_pulse)
  );

endmodule

// File: tb/tb_axil_regfile_slave.sv
// Scoreboard bench for axil_regfile_slave: stimulus pushes expected B/R
// responses, a monitor pops and compares on each handshake.
module tb_axil_regfile_slave;
  import axil_pkg::*;

  localparam int          DW = 32;
  localparam int          AW = 32;
  localparam int          NR = 16;
  localparam logic [31:0] RV = 32'h0000_5A5A;
`ifdef AXIL_REGFILE_SLVERR_EN
  localparam logic [1:0] OOR = 2'b10;
`else
  localparam logic [1:0] OOR = 2'b00;
`endif

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  logic               aclk = 1'b0;
  logic               aresetn;
  logic [NR*DW-1:0]   regs_out;
  logic [NR-1:0]      reg_wr_pulse;
  logic [NR*DW-1:0]   snap;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_b[$];
  rexp_t      exp_r[$];
  logic [1:0] eb;
  rexp_t      er;

  axil_regfile_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axil_regfile_slave #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .RESET_VALUE(RV)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .bus          (bus),
    .regs_out     (regs_out),
    .reg_wr_pulse (reg_wr_pulse)
  );

  always #5 aclk = ~aclk;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] reg_of(int i);
    return regs_out[i*DW +: DW];
  endfunction

  // Monitor: compare every B and R handshake against the scoreboard.
  always @(negedge aclk) begin
    if (bus.bvalid && bus.bready) begin
      if (exp_b.size() == 0) chk("b_unexpected", 64'd1, 64'd0);
      else begin
        eb = exp_b.pop_front();
        chk("bresp", 64'(bus.bresp), 64'(eb));
      end
    end
    if (bus.rvalid && bus.rready) begin
      if (exp_r.size() == 0) chk("r_unexpected", 64'd1, 64'd0);
      else begin
        er = exp_r.pop_front();
        chk("rdata", 64'(bus.rdata), 64'(er.data));
        chk("rresp", 64'(bus.rresp), 64'(er.resp));
      end
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic aw_send(input logic [31:0] addr);
    int n = 0;
    bus.awaddr = addr; bus.awvalid = 1'b1;
    @(negedge aclk);
    while (!bus.awready) begin
      if (++n > 50) begin chk("aw_timeout", 64'd0, 64'd1); break; end
      @(negedge aclk);
    end
    step();
    bus.awvalid = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] data, input logic [3:0] strb);
    int n = 0;
    bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1;
    @(negedge aclk);
    while (!bus.wready) begin
      if (++n > 50) begin chk("w_timeout", 64'd0, 64'd1); break; end
      @(negedge aclk);
    end
    step();
    bus.wvalid = 1'b0;
  endtask

  task automatic b_wait();
    int n = 0;
    bus.bready = 1'b1;
    @(negedge aclk);
    while (!bus.bvalid) begin
      if (++n > 50) begin chk("b_timeout", 64'd0, 64'd1); break; end
      @(negedge aclk);
    end
    step();
    bus.bready = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] resp);
    exp_b.push_back(resp);
    fork
      aw_send(addr);
      w_send(data, strb);
    join
    b_wait();
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] resp);
    int n = 0;
    exp_r.push_back('{data: data, resp: resp});
    bus.araddr = addr; bus.arvalid = 1'b1;
    @(negedge aclk);
    while (!bus.arready) begin
      if (++n > 50) begin chk("ar_timeout", 64'd0, 64'd1); break; end
      @(negedge aclk);
    end
    step();
    bus.arvalid = 1'b0;
    bus.rready  = 1'b1;
    n = 0;
    @(negedge aclk);
    while (!bus.rvalid) begin
      if (++n > 50) begin chk("r_timeout", 64'd0, 64'd1); break; end
      @(negedge aclk);
    end
    step();
    bus.rready = 1'b0;
    @(negedge aclk);
    chk("arready_after_r", 64'(bus.arready), 64'd1);
    step();
  endtask

  // Hold bready low for n cycles while checking the response stays put.
  task automatic b_stall(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      @(negedge aclk);
      chk({name, "_bvalid_hold"}, 64'(bus.bvalid), 64'd1);
      chk({name, "_bresp_hold"}, 64'(bus.bresp), 64'd0);
      step();
    end
    bus.bready = 1'b1;
    @(negedge aclk);
    step();
    bus.bready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    aresetn = 1'b0;
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0;  bus.wstrb = '0;  bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

    // Reset state
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_awready", 64'(bus.awready), 64'd0);
    chk("rst_wready", 64'(bus.wready), 64'd0);
    chk("rst_arready", 64'(bus.arready), 64'd0);
    chk("rst_bvalid", 64'(bus.bvalid), 64'd0);
    chk("rst_rvalid", 64'(bus.rvalid), 64'd0);
    chk("rst_resp", 64'({bus.bresp, bus.rresp}), 64'd0);
    chk("rst_rdata", 64'(bus.rdata), 64'd0);
    chk("rst_pulse", 64'(reg_wr_pulse), 64'd0);
    for (int i = 0; i < NR; i++) chk("rst_reg", 64'(reg_of(i)), 64'(RV));
    step();
    aresetn = 1'b1;
    step();
    @(negedge aclk);
    chk("post_rst_awready", 64'(bus.awready), 64'd1);
    chk("post_rst_wready", 64'(bus.wready), 64'd1);
    chk("post_rst_arready", 64'(bus.arready), 64'd1);
    step();

    // Read every register after reset
    for (int i = 0; i < NR; i++) axi_read(32'(i * 4), RV, 2'b00);

    // Same-cycle AW+W to reg 3
    exp_b.push_back(2'b00);
    bus.awaddr = 32'h0C; bus.awvalid = 1'b1;
    bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(negedge aclk);
    chk("wr3_ready", 64'({bus.awready, bus.wready}), 64'd3);
    step();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    @(negedge aclk);
    chk("wr3_bvalid", 64'(bus.bvalid), 64'd1);
    chk("wr3_pulse", 64'(reg_wr_pulse), 64'h0008);
    chk("wr3_regs_out", 64'(reg_of(3)), 64'hDEADBEEF);
    chk("wr3_awready_busy", 64'(bus.awready), 64'd0);
    step();
    bus.bready = 1'b1;
    @(negedge aclk);
    chk("wr3_pulse_one_cycle", 64'(reg_wr_pulse), 64'd0);
    step();
    bus.bready = 1'b0;
    @(negedge aclk);
    chk("wr3_bvalid_clear", 64'(bus.bvalid), 64'd0);
    step();
    axi_read(32'h0C, 32'hDEADBEEF, 2'b00);

    // Byte strobes on reg 5
    axi_write(32'h14, 32'h11223344, 4'hF, 2'b00);
    axi_write(32'h14, 32'hAABBCCDD, 4'b0101, 2'b00);
    chk("strb_regs_out", 64'(reg_of(5)), 64'h11BB33DD);
    axi_read(32'h14, 32'h11BB33DD, 2'b00);

    // W three cycles ahead of AW; a second W is offered but must wait
    exp_b.push_back(2'b00);
    bus.wdata = 32'h12345678; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(negedge aclk);
    chk("wfirst_wready", 64'(bus.wready), 64'd1);
    step();
    bus.wdata = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      chk("wfirst_no_second_w", 64'(bus.wready), 64'd0);
      chk("wfirst_no_commit", 64'(bus.bvalid), 64'd0);
      step();
    end
    bus.wvalid = 1'b0;
    bus.awaddr = 32'h1C; bus.awvalid = 1'b1;
    @(negedge aclk);
    chk("wfirst_awready", 64'(bus.awready), 64'd1);
    step();
    bus.awvalid = 1'b0;
    @(negedge aclk);
    chk("wfirst_bvalid", 64'(bus.bvalid), 64'd1);
    chk("wfirst_reg7", 64'(reg_of(7)), 64'h12345678);
    step();
    b_stall(4, "wfirst");

    // AW three cycles ahead of W
    exp_b.push_back(2'b00);
    bus.awaddr = 32'h20; bus.awvalid = 1'b1;
    @(negedge aclk);
    chk("awfirst_awready", 64'(bus.awready), 64'd1);
    step();
    bus.awaddr = 32'h24;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      chk("awfirst_no_second_aw", 64'(bus.awready), 64'd0);
      chk("awfirst_no_commit", 64'(bus.bvalid), 64'd0);
      step();
    end
    bus.awvalid = 1'b0;
    bus.wdata = 32'hCAFEF00D; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(negedge aclk);
    chk("awfirst_wready", 64'(bus.wready), 64'd1);
    step();
    bus.wvalid = 1'b0;
    @(negedge aclk);
    chk("awfirst_bvalid", 64'(bus.bvalid), 64'd1);
    chk("awfirst_reg8", 64'(reg_of(8)), 64'hCAFEF00D);
    chk("awfirst_reg9", 64'(reg_of(9)), 64'(RV));
    step();
    b_stall(4, "awfirst");

    // Out-of-range address
    snap = regs_out;
    axi_write(32'h40, 32'hFFFFFFFF, 4'hF, OOR);
    chk("oor_regs_unchanged", 64'(regs_out == snap), 64'd1);
    axi_read(32'h40, 32'h0, OOR);

    // Same-edge read and write of reg 2
    axi_write(32'h08, 32'h1, 4'hF, 2'b00);
    exp_b.push_back(2'b00);
    exp_r.push_back('{data: 32'h1, resp: 2'b00});
    bus.awaddr = 32'h08; bus.wdata = 32'h2; bus.wstrb = 4'hF;
    bus.araddr = 32'h08;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
    bus.bready = 1'b1; bus.rready = 1'b1;
    @(negedge aclk);
    chk("same_edge_ready", 64'({bus.awready, bus.wready, bus.arready}), 64'd7);
    step();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    @(negedge aclk);
    chk("same_edge_valids", 64'({bus.bvalid, bus.rvalid}), 64'd3);
    step();
    bus.bready = 1'b0; bus.rready = 1'b0;
    axi_read(32'h08, 32'h2, 2'b00);

    // Reset while a write response is pending
    bus.awaddr = 32'h10; bus.wdata = 32'h77; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    step();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    @(negedge aclk);
    chk("rstmid_bvalid", 64'(bus.bvalid), 64'd1);
    chk("rstmid_reg4", 64'(reg_of(4)), 64'h77);
    aresetn = 1'b0;
    #1;
    chk("rstmid_bvalid_drop", 64'(bus.bvalid), 64'd0);
    chk("rstmid_reg4_reset", 64'(reg_of(4)), 64'(RV));
    chk("rstmid_reg3_reset", 64'(reg_of(3)), 64'(RV));
    chk("rstmid_awready", 64'(bus.awready), 64'd0);
    step();
    aresetn = 1'b1;
    bus.bready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      chk("rstmid_no_resp", 64'(bus.bvalid), 64'd0);
    end
    step();
    bus.bready = 1'b0;
    axi_read(32'h10, RV, 2'b00);

    chk("b_queue_empty", 64'(exp_b.size()), 64'd0);
    chk("r_queue_empty", 64'(exp_r.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
